fifo_wr_arbiter: RTL

//  Round-robin write-port arbiter for the synchronous FIFO (cs/wr_en/data_in/full interface).

---
 rtl/fifo_arb_pkg.sv | 30 +++
 rtl/fifo_wr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_arb_pkg
// Purpose  : Shared definitions for FIFO port arbiters: arbiter state
//            encoding and a width helper for id and beat counters.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter state: one bit is enough for the two-state grant machine.
    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 1'b0;
    localparam arb_state_t ST_LOCKED = 1'b1;

    // Ceiling log2 with a floor of 1 so a count of 1 still yields a legal
    // one-bit vector for ids and counters.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker. Returns the first set bit of
//            the request vector searching upward from (last_owner + 1),
//            wrapping at NUM_REQ. last_owner itself is searched last.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    logic [ID_W-1:0] w_cand;

    // Walk the candidates from the farthest to the nearest so that the
    // nearest set bit after last_owner is the one left standing.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = ID_W'((int'(last_owner) + k) % NUM_REQ);
            if (req[w_cand]) begin
                found = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin, burst-locked arbiter sharing one synchronous FIFO
//            write port among NUM_REQ valid/ready producers. A winner keeps
//            the port until it writes a beat flagged last or until it has
//            written MAX_BURST beats. Arbitration takes one idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_cs,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [clog2_min1(NUM_REQ)-1:0] grant_id,
    output logic                          busy
);

    localparam int ID_W  = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(MAX_BURST);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [ID_W-1:0]  r_owner;
    logic [ID_W-1:0]  r_last_owner;
    logic [CNT_W-1:0] r_beat_cnt;

    logic             w_pick_found;
    logic [ID_W-1:0]  w_pick_idx;
    logic             w_xfer;
    logic             w_release;

    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];

    // Unpack the flat requester data bus into one word per requester.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
            assign w_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_owner (r_last_owner),
        .found      (w_pick_found),
        .idx        (w_pick_idx)
    );

    // A beat moves only while a grant is held, the owner offers data and the
    // FIFO has room. The grant ends on the last-flagged beat or a full burst.
    assign w_xfer    = (r_state == ST_LOCKED) && req_valid[r_owner] && !fifo_full;
    assign w_release = w_xfer &&
                       (req_last[r_owner] || (r_beat_cnt == CNT_W'(MAX_BURST - 1)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: lock onto a winner when anyone asks, return to idle on release.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Outputs: the owner's data is presented for the whole grant; only the
    // owner can see ready, and only when the beat is actually written.
    always_comb begin
        req_ready    = '0;
        fifo_cs      = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        busy         = 1'b0;
        if (r_state == ST_LOCKED) begin
            fifo_cs              = 1'b1;
            busy                 = 1'b1;
            fifo_wr_en           = w_xfer;
            fifo_data_in         = w_slice[r_owner];
            req_ready[r_owner]   = w_xfer;
        end
    end

    // Owner, round-robin pointer and beat counter. The counter only moves on
    // a written beat, so full-FIFO stalls and owner bubbles freeze it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= '0;
            r_last_owner <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_beat_cnt <= '0;
                    if (w_pick_found) begin
                        r_owner <= w_pick_idx;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                    if (w_release) begin
                        r_last_owner <= r_owner;
                    end
                end
                default: begin
                    r_beat_cnt <= '0;
                end
            endcase
        end
    end

    assign grant_id = r_owner;

`ifndef SYNTHESIS
    // Protocol invariants of the write port.
    a_wr_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_wr_en |-> !fifo_full);
    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_no_wr_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_IDLE) |-> !fifo_wr_en);
`endif

endmodule : fifo_wr_arbiter
`default_nettype wire
